// File: rtl/pipe_stage_skid.sv
// Single pipeline stage with a two-entry (main + skid) buffer, registered back-pressure,
// a constant increment on every accepted word and a saturating stall-cycle counter.
module pipe_stage_skid #(
    parameter int unsigned     DATA_W = 16,
    parameter longint unsigned INC    = 1,
    parameter int unsigned     CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_internal_stall,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_stall,
    output logic              o_current_ce,
    input  logic              i_stall,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic [1:0]        o_count,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StBusy  = 2'b01,
        StFull  = 2'b10
    } state_e;

    localparam logic [DATA_W-1:0] INC_W   = DATA_W'(INC);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    state_e             r_state;
    state_e             w_state_nxt;
    logic [DATA_W-1:0]  r_main;
    logic [DATA_W-1:0]  r_skid;
    logic [DATA_W-1:0]  w_main_nxt;
    logic [DATA_W-1:0]  w_skid_nxt;
    logic [DATA_W-1:0]  w_word;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               w_accept;
    logic               w_xfer;
    logic               w_cnt_en;

    // Back-pressure comes straight from the state register so i_stall never reaches o_stall.
    assign o_stall      = (r_state == StFull);
    assign w_accept     = i_valid & ~o_stall & ~i_flush;
    assign o_current_ce = w_accept;
    assign o_valid      = (r_state != StEmpty) & ~i_internal_stall;
    assign w_xfer       = o_valid & ~i_stall;
    assign w_word       = i_data + INC_W;
    assign o_data       = r_main;
    assign o_stall_cnt  = r_stall_cnt;
    assign w_cnt_en     = (r_state != StEmpty) & (i_stall | i_internal_stall) & ~i_flush;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (i_flush) begin
            w_state_nxt = StEmpty;
        end else begin
            case (r_state)
                StEmpty: begin
                    if (w_accept) begin
                        w_state_nxt = StBusy;
                        w_main_nxt  = w_word;
                    end
                end
                StBusy: begin
                    if (w_accept && w_xfer) begin
                        w_main_nxt = w_word;
                    end else if (w_accept) begin
                        w_state_nxt = StFull;
                        w_skid_nxt  = w_word;
                    end else if (w_xfer) begin
                        w_state_nxt = StEmpty;
                    end
                end
                StFull: begin
                    if (w_xfer) begin
                        w_state_nxt = StBusy;
                        w_main_nxt  = r_skid;
                    end
                end
                default: w_state_nxt = StEmpty;
            endcase
        end
    end

    always_comb begin
        case (r_state)
            StBusy:  o_count = 2'd1;
            StFull:  o_count = 2'd2;
            default: o_count = 2'd0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StEmpty;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    // Flush does not clear the counter; it only suppresses counting in the flush cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (w_cnt_en && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule
